fifo_overflow_ctrl: RTL and testbench

//  Parametrised single-clock overflow FIFO: a push on a full queue never stalls the producer.

---
 rtl/fifo_overflow_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fifo_overflow_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_overflow_ctrl.sv
// Single-clock overflow FIFO that never stalls its producer. When the queue is full,
// a push either replaces the oldest entry or is discarded, and the drop is counted.
module fifo_overflow_ctrl #(
   parameter int DW        = 16,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = 3,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         drop_new,
   input  logic                         push,
   input  logic [DW-1:0]                push_data,
   input  logic                         pop,
   output logic [DW-1:0]                pop_data,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         almost_full,
   output logic                         overflow,
   output logic                         ovf_sticky,
   output logic                         udf_sticky,
   output logic [CNT_W-1:0]             drop_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
   localparam logic [PW-1:0] P_LAST  = PW'(DEPTH - 1);

   // Binary pointer advance with wrap at DEPTH-1, so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
      return (p == P_LAST) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   logic [DW-1:0]    r_mem [0:DEPTH-1];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_valid;
   logic             r_full;
   logic             r_almost_full;
   logic             r_overflow;
   logic             r_ovf_sticky;
   logic             r_udf_sticky;
   logic [CNT_W-1:0] r_drop_cnt;

   logic             w_empty;
   logic             w_is_full;
   logic             w_wr_en;
   logic             w_wr_adv;
   logic             w_rd_adv;
   logic             w_drop;
   logic             w_udf;
   logic [CW-1:0]    w_count_nxt;
   logic [CNT_W-1:0] w_drop_cnt_nxt;

   assign w_empty   = (r_count == {CW{1'b0}});
   assign w_is_full = (r_count == C_DEPTH);

   // Decode push/pop against the current occupancy into write, pointer and flag actions.
   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_adv    = 1'b0;
      w_rd_adv    = 1'b0;
      w_drop      = 1'b0;
      w_udf       = 1'b0;
      w_count_nxt = r_count;
      case ({push, pop})
         2'b10: begin
            if (!w_is_full) begin
               w_wr_en     = 1'b1;
               w_wr_adv    = 1'b1;
               w_count_nxt = r_count + CW'(1);
            end else if (!drop_new) begin
               // Drop-oldest: the write lands on the head slot, so the head moves on too.
               w_wr_en  = 1'b1;
               w_wr_adv = 1'b1;
               w_rd_adv = 1'b1;
               w_drop   = 1'b1;
            end else begin
               w_drop = 1'b1;
            end
         end
         2'b01: begin
            if (!w_empty) begin
               w_rd_adv    = 1'b1;
               w_count_nxt = r_count - CW'(1);
            end else begin
               w_udf = 1'b1;
            end
         end
         2'b11: begin
            if (!w_empty) begin
               w_wr_en  = 1'b1;
               w_wr_adv = 1'b1;
               w_rd_adv = 1'b1;
            end else begin
               w_wr_en     = 1'b1;
               w_wr_adv    = 1'b1;
               w_udf       = 1'b1;
               w_count_nxt = r_count + CW'(1);
            end
         end
         default: begin
            w_wr_en = 1'b0;
         end
      endcase
   end

   // Saturating drop counter next value.
   always_comb begin
      w_drop_cnt_nxt = r_drop_cnt;
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
         w_drop_cnt_nxt = r_drop_cnt + CNT_W'(1);
      end else begin
         w_drop_cnt_nxt = r_drop_cnt;
      end
   end

   // Entry storage; deliberately not reset, contents are only visible while valid.
   always_ff @(posedge clk) begin
      if (w_wr_en && !flush) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Queue pointers, occupancy, status flags and drop accounting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr      <= {PW{1'b0}};
         r_rd_ptr      <= {PW{1'b0}};
         r_count       <= {CW{1'b0}};
         r_valid       <= 1'b0;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_overflow    <= 1'b0;
         r_ovf_sticky  <= 1'b0;
         r_udf_sticky  <= 1'b0;
         r_drop_cnt    <= {CNT_W{1'b0}};
      end else if (flush) begin
         r_wr_ptr      <= {PW{1'b0}};
         r_rd_ptr      <= {PW{1'b0}};
         r_count       <= {CW{1'b0}};
         r_valid       <= 1'b0;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_overflow    <= 1'b0;
         r_ovf_sticky  <= 1'b0;
         r_udf_sticky  <= 1'b0;
         r_drop_cnt    <= {CNT_W{1'b0}};
      end else begin
         if (w_wr_adv) begin
            r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         end
         if (w_rd_adv) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         r_count       <= w_count_nxt;
         r_valid       <= (w_count_nxt != {CW{1'b0}});
         r_full        <= (w_count_nxt == C_DEPTH);
         r_almost_full <= (w_count_nxt >= C_AF);
         r_overflow    <= w_drop;
         r_ovf_sticky  <= r_ovf_sticky | w_drop;
         r_udf_sticky  <= r_udf_sticky | w_udf;
         r_drop_cnt    <= w_drop_cnt_nxt;
      end
   end

   assign pop_data    = r_mem[r_rd_ptr];
   assign valid       = r_valid;
   assign count       = r_count;
   assign full        = r_full;
   assign almost_full = r_almost_full;
   assign overflow    = r_overflow;
   assign ovf_sticky  = r_ovf_sticky;
   assign udf_sticky  = r_udf_sticky;
   assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_fifo_overflow_ctrl.sv
// Drives a DEPTH=4 and a DEPTH=3/CNT_W=2 instance with identical stimulus and checks both
// against a list-based queue model, plus literal expectations for the directed scenarios.
module tb_fifo_overflow_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        drop_new = 1'b0;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [15:0] push_data = 16'h0000;

   logic [15:0] pd4, pd3;
   logic        v4, v3, f4, f3, af4, af3, ov4, ov3, os4, os3, us4, us3;
   logic [2:0]  cnt4;
   logic [1:0]  cnt3;
   logic [15:0] dc4;
   logic [1:0]  dc3;

   int n_checks = 0;
   int n_errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   fifo_overflow_ctrl #(.DW(16), .DEPTH(4), .AF_THRESH(3), .CNT_W(16)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .drop_new(drop_new), .push(push),
      .push_data(push_data), .pop(pop), .pop_data(pd4), .valid(v4), .count(cnt4),
      .full(f4), .almost_full(af4), .overflow(ov4), .ovf_sticky(os4),
      .udf_sticky(us4), .drop_cnt(dc4));

   fifo_overflow_ctrl #(.DW(16), .DEPTH(3), .AF_THRESH(2), .CNT_W(2)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .drop_new(drop_new), .push(push),
      .push_data(push_data), .pop(pop), .pop_data(pd3), .valid(v3), .count(cnt3),
      .full(f3), .almost_full(af3), .overflow(ov3), .ovf_sticky(os3),
      .udf_sticky(us3), .drop_cnt(dc3));

   // Reference model: an ordered list per instance, index 0 is the oldest entry.
   int          DEP  [2] = '{4, 3};
   int          AFT  [2] = '{3, 2};
   int          CMAX [2] = '{65535, 3};
   logic [15:0] mq   [2][0:7];
   int          mc   [2] = '{0, 0};
   logic        mo   [2] = '{1'b0, 1'b0};
   logic        mos  [2] = '{1'b0, 1'b0};
   logic        mus  [2] = '{1'b0, 1'b0};
   int          mdc  [2] = '{0, 0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_shift(input int k);
      for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
      mc[k] = mc[k] - 1;
   endtask

   task automatic model_step(input int k);
      if (flush) begin
         mc[k] = 0; mo[k] = 1'b0; mos[k] = 1'b0; mus[k] = 1'b0; mdc[k] = 0;
      end else begin
         mo[k] = 1'b0;
         if (pop) begin
            if (mc[k] > 0) m_shift(k);
            else mus[k] = 1'b1;
         end
         if (push) begin
            if (mc[k] < DEP[k]) begin
               mq[k][mc[k]] = push_data;
               mc[k] = mc[k] + 1;
            end else begin
               mo[k] = 1'b1;
               mos[k] = 1'b1;
               if (mdc[k] < CMAX[k]) mdc[k] = mdc[k] + 1;
               if (!drop_new) begin
                  m_shift(k);
                  mq[k][mc[k]] = push_data;
                  mc[k] = mc[k] + 1;
               end
            end
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            mc[k] = 0; mo[k] = 1'b0; mos[k] = 1'b0; mus[k] = 1'b0; mdc[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   task automatic cmp_inst(input int k, input logic [15:0] pd, input logic v, input int cnt,
                           input logic f, input logic af, input logic ov, input logic os,
                           input logic us, input int dc);
      string p;
      p = (k == 0) ? "d4" : "d3";
      chk({p, ".count"}, cnt, mc[k]);
      chk({p, ".valid"}, 32'(v), 32'(mc[k] != 0));
      chk({p, ".full"}, 32'(f), 32'(mc[k] == DEP[k]));
      chk({p, ".almost_full"}, 32'(af), 32'(mc[k] >= AFT[k]));
      chk({p, ".overflow"}, 32'(ov), 32'(mo[k]));
      chk({p, ".ovf_sticky"}, 32'(os), 32'(mos[k]));
      chk({p, ".udf_sticky"}, 32'(us), 32'(mus[k]));
      chk({p, ".drop_cnt"}, dc, mdc[k]);
      if (mc[k] > 0) chk({p, ".pop_data"}, 32'(pd), 32'(mq[k][0]));
   endtask

   // Compare both instances against the model once per cycle, mid-period.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp_inst(0, pd4, v4, int'(cnt4), f4, af4, ov4, os4, us4, int'(dc4));
         cmp_inst(1, pd3, v3, int'(cnt3), f3, af3, ov3, os3, us3, int'(dc3));
      end
   end

   task automatic cyc(input logic pu, input logic po, input logic [15:0] d,
                      input logic dn, input logic fl);
      push = pu; pop = po; push_data = d; drop_new = dn; flush = fl;
      @(posedge clk);
      @(negedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0;
   endtask

   task automatic fill4(input logic [15:0] base);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, base + 16'(i), 1'b0, 1'b0);
   endtask

   task automatic pop_expect(input string name, input logic [15:0] exp);
      chk(name, 32'(pd4), 32'(exp));
      cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      #2;
      chk("reset.count", 32'(cnt4), 32'd0);
      chk("reset.valid", 32'(v4), 32'd0);
      chk("reset.drop_cnt", 32'(dc4), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      #1;

      // Fill: occupancy, almost-full and full thresholds, head is first entry.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 16'hA000 + 16'(i), 1'b0, 1'b0);
         chk("fill.count", 32'(cnt4), 32'(i + 1));
      end
      chk("fill.af", 32'(af4), 32'd1);
      chk("fill.full", 32'(f4), 32'd1);
      chk("fill.head", 32'(pd4), 32'h0000A000);

      // Drop-oldest.
      cyc(1'b1, 1'b0, 16'hB000, 1'b0, 1'b0);
      chk("dold.overflow", 32'(ov4), 32'd1);
      chk("dold.drop_cnt", 32'(dc4), 32'd1);
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk("dold.pulse_end", 32'(ov4), 32'd0);
      pop_expect("dold.pop0", 16'hA001);
      pop_expect("dold.pop1", 16'hA002);
      pop_expect("dold.pop2", 16'hA003);
      pop_expect("dold.pop3", 16'hB000);
      chk("dold.empty", 32'(v4), 32'd0);

      // Drop-newest.
      cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      fill4(16'hA000);
      cyc(1'b1, 1'b0, 16'hB000, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 16'hB001, 1'b1, 1'b0);
      chk("dnew.drop_cnt", 32'(dc4), 32'd2);
      chk("dnew.sticky", 32'(os4), 32'd1);
      pop_expect("dnew.pop0", 16'hA000);
      pop_expect("dnew.pop1", 16'hA001);
      pop_expect("dnew.pop2", 16'hA002);
      pop_expect("dnew.pop3", 16'hA003);

      // Simultaneous push and pop while full is not a drop.
      fill4(16'hA000);
      cyc(1'b1, 1'b1, 16'hC000, 1'b0, 1'b0);
      chk("pp.overflow", 32'(ov4), 32'd0);
      chk("pp.count", 32'(cnt4), 32'd4);
      pop_expect("pp.pop0", 16'hA001);
      pop_expect("pp.pop1", 16'hA002);
      pop_expect("pp.pop2", 16'hA003);
      pop_expect("pp.pop3", 16'hC000);

      // Underflow on empty; push and pop on empty enqueues.
      cyc(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
      chk("udf.sticky", 32'(us4), 32'd1);
      chk("udf.count", 32'(cnt4), 32'd0);
      cyc(1'b1, 1'b1, 16'hD000, 1'b0, 1'b0);
      chk("udf.pp_count", 32'(cnt4), 32'd1);
      chk("udf.pp_head", 32'(pd4), 32'h0000D000);

      // Flush clears everything on the next cycle.
      cyc(1'b1, 1'b0, 16'hE000, 1'b0, 1'b1);
      chk("flush.count", 32'(cnt4), 32'd0);
      chk("flush.udf", 32'(us4), 32'd0);
      chk("flush.ovf", 32'(os4), 32'd0);
      chk("flush.drop_cnt", 32'(dc4), 32'd0);

      // Saturation of the 2-bit counter: 3 fills then 5 drops.
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'h5000 + 16'(i), 1'b0, 1'b0);
      chk("sat.dc3", 32'(dc3), 32'd3);
      chk("sat.dc4", 32'(dc4), 32'd4);
      chk("sat.head3", 32'(pd3), 32'h00005005);

      // Randomized mix with occasional flush.
      for (int n = 0; n < 600; n++) begin
         cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
             16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 3));
      end

      // Asynchronous reset mid-push.
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 16'h7000 + 16'(i), 1'b0, 1'b0);
      push = 1'b1; push_data = 16'h7777;
      @(posedge clk);
      #2;
      rst = 1'b1;
      push = 1'b0;
      #1;
      chk("arst.count4", 32'(cnt4), 32'd0);
      chk("arst.valid4", 32'(v4), 32'd0);
      chk("arst.count3", 32'(cnt3), 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h9000 + 16'(i), 1'b0, 1'b0);
      chk("post.count4", 32'(cnt4), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
